sram_access_ctrl: RTL and testbench
===================================

// Module: sram_access_ctrl
// PURPOSE
//  Arbiter/address generator directly upstream of the SRAM model. Streams SDRAM-buffer words into a
//  two-row ping-pong row cache, streams window-buffer results into the output array, and serves
//  random row-cache reads for the window buffer. Issues at most one SRAM operation per cycle.
// PARAMETERS
//  COL_W     13         column index width; row length = 2**COL_W words
//  OUT_BASE  26'h4000   first SRAM address of the output array
//  OUT_LEN   16384      output array length in words; must satisfy OUT_LEN >= 1
// PORTS
//  clk             in   1      system clock
//  rst             in   1      synchronous reset, active-high
//  frame_start     in   1      1-cycle pulse: rewind all pointers (as reset, outputs unaffected)
//  sd_valid        in   1      SDRAM-buffer word available
//  sd_data         in   32     SDRAM-buffer word
//  sd_ready        out  1      word accepted this cycle (sd_valid & sd_ready)
//  wb_valid        in   1      window-buffer result available
//  wb_data         in   32     window-buffer result
//  wb_ready        out  1      result accepted this cycle
//  rd_req          in   1      row-cache read request
//  rd_row          in   1      row select of read
//  rd_col          in   COL_W  column of read
//  rd_ready        out  1      read request accepted this cycle
//  rd_data         out  32     read data
//  rd_valid        out  1      rd_data valid (1-cycle pulse)
//  row_done        out  1      1-cycle pulse: last column of a cache row written
//  row_done_idx    out  1      row that completed (valid with row_done)
//  sram_enable     out  1      SRAM enable
//  sram_mode       out  1      1 = read, 0 = write
//  sram_addrCalcMode out 1     1 = write sram_sdram_data, 0 = write sram_wb_data
//  sram_address    out  26     SRAM word address
//  sram_sdram_data out  32     = sd_data (combinational pass-through)
//  sram_wb_data    out  32     = wb_data (combinational pass-through)
//  sram_out_data   in   32     SRAM read data
//  sram_dataReadValid in 1     SRAM read-data valid
// BEHAVIOUR
//  - Reset: state IDLE, sd_ptr = 0, sd_row = 0, out_ptr = 0, all ready/valid/pulse outputs 0.
//  - SRAM control outputs are combinational from state and grants; sram_enable = 0 when no grant.
//  - FSM IDLE: grant by fixed priority rd_req > sd_valid > wb_valid, one grant per cycle.
//     * read grant: rd_ready=1, sram_enable=1, sram_mode=1, sram_address={0,rd_row,rd_col}; -> RD_WAIT.
//     * sd grant: sd_ready=1, mode=0, addrCalcMode=1, address={0,sd_row,sd_ptr}; stay IDLE.
//     * wb grant: wb_ready=1, mode=0, addrCalcMode=0, address=OUT_BASE+out_ptr; stay IDLE.
//  - RD_WAIT: no grants, all readies 0, sram_enable=0. Next cycle rd_valid=1, rd_data=sram_out_data
//    (registered on sram_dataReadValid); -> IDLE. Read latency: accept at N, rd_valid at N+2.
//  - sd_ptr increments per accepted sd word; at 2**COL_W-1 wraps to 0, toggles sd_row, and
//    row_done/row_done_idx (old row) pulse the following cycle.
//  - out_ptr increments per accepted wb word; at OUT_LEN-1 wraps to 0.
//  - frame_start: pointers to reset values next cycle; same-cycle grant still uses old pointers; a
//    pending RD_WAIT completes normally.
//  - rst mid-read: RD_WAIT abandoned, no rd_valid produced.
//  - sd/wb waiting while rd_req held continuously starve; upstream guarantees rd_req gaps.
// TESTING
//  1 Reset: drive rst 1 cycle with all valids high -> all readies, rd_valid, sram_enable = 0.
//  2 sd stream 3 words 0xA0..0xA2 -> sram writes at addr 0,1,2, addrCalcMode=1, sd_ready 3 cycles.
//  3 sd stream 8192 words -> row_done pulse with idx 0 after word 8191; word 8192 written at 0x2000.
//  4 Read row 1 col 5 holding 0xDEADBEEF -> rd_ready at N, rd_valid & rd_data=0xDEADBEEF at N+2.
//  5 rd_req, sd_valid, wb_valid same cycle -> read first, sd at N+2, wb at N+3.
//  6 OUT_LEN=4, 5 wb words -> writes at 0x4000..0x4003 then 0x4000; rst during RD_WAIT -> no rd_valid.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: single-port SRAM arbiter / address generator.
// Latency: writes issued the grant cycle; reads accepted at N return rd_valid at N+2.
// Backpressure: fixed priority rd > sd > wb; nothing granted while a read is outstanding or in reset.
module sram_access_ctrl #(
  parameter int          COL_W    = 13,
  parameter logic [25:0] OUT_BASE = 26'h4000,
  parameter int          OUT_LEN  = 16384
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_frame_start,
  input  logic             i_sd_valid,
  input  logic [31:0]      i_sd_data,
  output logic             o_sd_ready,
  input  logic             i_wb_valid,
  input  logic [31:0]      i_wb_data,
  output logic             o_wb_ready,
  input  logic             i_rd_req,
  input  logic             i_rd_row,
  input  logic [COL_W-1:0] i_rd_col,
  output logic             o_rd_ready,
  output logic [31:0]      o_rd_data,
  output logic             o_rd_valid,
  output logic             o_row_done,
  output logic             o_row_done_idx,
  output logic             o_sram_enable,
  output logic             o_sram_mode,
  output logic             o_sram_addrCalcMode,
  output logic [25:0]      o_sram_address,
  output logic [31:0]      o_sram_sdram_data,
  output logic [31:0]      o_sram_wb_data,
  input  logic [31:0]      i_sram_out_data,
  input  logic             i_sram_dataReadValid
);

  localparam int             OPW      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam logic [OPW-1:0] OUT_LAST = OPW'(OUT_LEN - 1);
  localparam logic [COL_W-1:0] COL_LAST = '1;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_RD_WAIT = 1'b1;

  logic [0:0]       r_state;
  logic [COL_W-1:0] r_sd_ptr;
  logic             r_sd_row;
  logic [OPW-1:0]   r_out_ptr;
  logic             r_rd_valid;
  logic [31:0]      r_rd_data;
  logic             r_row_done;
  logic             r_row_done_idx;

  logic w_idle;
  logic w_rd_gnt;
  logic w_sd_gnt;
  logic w_wb_gnt;

  // Grants are gated by reset so nothing reaches the SRAM while rst is held.
  assign w_idle   = (r_state == S_IDLE) && !i_rst;
  assign w_rd_gnt = w_idle && i_rd_req;
  assign w_sd_gnt = w_idle && !i_rd_req && i_sd_valid;
  assign w_wb_gnt = w_idle && !i_rd_req && !i_sd_valid && i_wb_valid;

  assign o_rd_ready        = w_rd_gnt;
  assign o_sd_ready        = w_sd_gnt;
  assign o_wb_ready        = w_wb_gnt;
  assign o_rd_valid        = r_rd_valid;
  assign o_rd_data         = r_rd_data;
  assign o_row_done        = r_row_done;
  assign o_row_done_idx    = r_row_done_idx;
  assign o_sram_sdram_data = i_sd_data;
  assign o_sram_wb_data    = i_wb_data;

  // SRAM command decode: one operation per cycle, idle bus when nothing is granted.
  always_comb begin
    o_sram_enable       = 1'b0;
    o_sram_mode         = 1'b0;
    o_sram_addrCalcMode = 1'b0;
    o_sram_address      = '0;
    if (w_rd_gnt) begin
      o_sram_enable  = 1'b1;
      o_sram_mode    = 1'b1;
      o_sram_address = {{(25 - COL_W){1'b0}}, i_rd_row, i_rd_col};
    end else if (w_sd_gnt) begin
      o_sram_enable       = 1'b1;
      o_sram_addrCalcMode = 1'b1;
      o_sram_address      = {{(25 - COL_W){1'b0}}, r_sd_row, r_sd_ptr};
    end else if (w_wb_gnt) begin
      o_sram_enable  = 1'b1;
      o_sram_address = OUT_BASE + {{(26 - OPW){1'b0}}, r_out_ptr};
    end
  end

  // Two-state FSM: a read grant parks one cycle in RD_WAIT while the SRAM answers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else if (r_state == S_RD_WAIT) begin
      r_state <= S_IDLE;
    end else if (w_rd_gnt) begin
      r_state <= S_RD_WAIT;
    end
  end

  // Write pointers: the grant uses the current pointer; frame_start rewinds afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_frame_start) begin
      r_sd_ptr  <= '0;
      r_sd_row  <= 1'b0;
      r_out_ptr <= '0;
    end else begin
      if (w_sd_gnt) begin
        r_sd_ptr <= r_sd_ptr + 1'b1;
        if (r_sd_ptr == COL_LAST) begin
          r_sd_row <= ~r_sd_row;
        end
      end
      if (w_wb_gnt) begin
        r_out_ptr <= (r_out_ptr == OUT_LAST) ? '0 : r_out_ptr + 1'b1;
      end
    end
  end

  // Read return: one-cycle rd_valid pulse leaving RD_WAIT; reset abandons it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= (r_state == S_RD_WAIT);
      if ((r_state == S_RD_WAIT) && i_sram_dataReadValid) begin
        r_rd_data <= i_sram_out_data;
      end
    end
  end

  // Row completion pulse, reported the cycle after the last column is written.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row_done     <= 1'b0;
      r_row_done_idx <= 1'b0;
    end else begin
      r_row_done     <= w_sd_gnt && (r_sd_ptr == COL_LAST);
      r_row_done_idx <= r_sd_row;
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: directed steps then random traffic against a cycle-count model.
// Model tracks word counts and read times; addresses derive from counts with plain arithmetic.
// A small SRAM model answers reads one cycle after issue.
module tb_sram_access_ctrl;
  localparam int          COL_W    = 13;
  localparam int          OUT_LEN  = 4;
  localparam logic [25:0] OUT_BASE = 26'h4000;
  localparam int          ROW_LEN  = 1 << COL_W;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_frame_start = 1'b0;
  logic        i_sd_valid = 1'b0;
  logic [31:0] i_sd_data = '0;
  logic        i_wb_valid = 1'b0;
  logic [31:0] i_wb_data = '0;
  logic        i_rd_req = 1'b0;
  logic        i_rd_row = 1'b0;
  logic [COL_W-1:0] i_rd_col = '0;
  logic        o_sd_ready, o_wb_ready, o_rd_ready, o_rd_valid;
  logic [31:0] o_rd_data;
  logic        o_row_done, o_row_done_idx;
  logic        o_sram_enable, o_sram_mode, o_sram_addrCalcMode;
  logic [25:0] o_sram_address;
  logic [31:0] o_sram_sdram_data, o_sram_wb_data;
  bit   [31:0] sram_out_data;
  bit          sram_rv;

  sram_access_ctrl #(.COL_W(COL_W), .OUT_BASE(OUT_BASE), .OUT_LEN(OUT_LEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start),
    .i_sd_valid(i_sd_valid), .i_sd_data(i_sd_data), .o_sd_ready(o_sd_ready),
    .i_wb_valid(i_wb_valid), .i_wb_data(i_wb_data), .o_wb_ready(o_wb_ready),
    .i_rd_req(i_rd_req), .i_rd_row(i_rd_row), .i_rd_col(i_rd_col),
    .o_rd_ready(o_rd_ready), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_row_done(o_row_done), .o_row_done_idx(o_row_done_idx),
    .o_sram_enable(o_sram_enable), .o_sram_mode(o_sram_mode),
    .o_sram_addrCalcMode(o_sram_addrCalcMode), .o_sram_address(o_sram_address),
    .o_sram_sdram_data(o_sram_sdram_data), .o_sram_wb_data(o_sram_wb_data),
    .i_sram_out_data(sram_out_data), .i_sram_dataReadValid(sram_rv)
  );

  always #5 i_clk = ~i_clk;

  // SRAM model: writes land on the edge, read data comes back the next cycle.
  bit [31:0] mem [0:32767];
  always @(posedge i_clk) begin
    if (o_sram_enable && o_sram_mode) begin
      sram_out_data <= mem[o_sram_address[14:0]];
      sram_rv       <= 1'b1;
    end else begin
      sram_rv <= 1'b0;
    end
    if (o_sram_enable && !o_sram_mode)
      mem[o_sram_address[14:0]] <= o_sram_addrCalcMode ? o_sram_sdram_data : o_sram_wb_data;
  end

  // Reference state
  bit [31:0] ref_mem [0:32767];
  int cyc = 0, sd_cnt = 0, wb_cnt = 0, read_at = -10, done_at = -10;
  logic done_idx = 1'b0;
  logic [31:0] rd_exp = '0;
  int n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model, cross the rising edge.
  task automatic step(input logic rdq, input logic row, input logic [COL_W-1:0] col,
                      input logic sdv, input logic [31:0] sdd,
                      input logic wbv, input logic [31:0] wbd,
                      input logic fs, input logic rs);
    logic busy, g_rd, g_sd, g_wb;
    logic [25:0] ea;
    i_rd_req = rdq; i_rd_row = row; i_rd_col = col;
    i_sd_valid = sdv; i_sd_data = sdd; i_wb_valid = wbv; i_wb_data = wbd;
    i_frame_start = fs; i_rst = rs;
    #4;
    busy = !rs && (cyc == read_at + 1);
    g_rd = !rs && !busy && rdq;
    g_sd = !rs && !busy && !rdq && sdv;
    g_wb = !rs && !busy && !rdq && !sdv && wbv;
    ea = '0;
    if (g_rd)      ea = 26'(row) * 26'(ROW_LEN) + 26'(col);
    else if (g_sd) ea = 26'(sd_cnt % (2 * ROW_LEN));
    else if (g_wb) ea = OUT_BASE + 26'(wb_cnt % OUT_LEN);
    chk("rd_ready", 32'(o_rd_ready), 32'(g_rd));
    chk("sd_ready", 32'(o_sd_ready), 32'(g_sd));
    chk("wb_ready", 32'(o_wb_ready), 32'(g_wb));
    chk("sram_enable", 32'(o_sram_enable), 32'(g_rd | g_sd | g_wb));
    if (g_rd | g_sd | g_wb) begin
      chk("sram_mode", 32'(o_sram_mode), 32'(g_rd));
      chk("sram_address", 32'(o_sram_address), 32'(ea));
      if (!g_rd) chk("addrCalcMode", 32'(o_sram_addrCalcMode), 32'(g_sd));
      if (g_sd)  chk("sdram_data", o_sram_sdram_data, sdd);
    end
    chk("rd_valid", 32'(o_rd_valid), 32'(cyc == read_at + 2));
    if (cyc == read_at + 2) chk("rd_data", o_rd_data, rd_exp);
    chk("row_done", 32'(o_row_done), 32'(cyc == done_at));
    if (cyc == done_at) chk("row_done_idx", 32'(o_row_done_idx), 32'(done_idx));
    if (rs) begin
      sd_cnt = 0; wb_cnt = 0; read_at = -10; done_at = -10;
    end else begin
      if (g_rd) begin
        read_at = cyc;
        rd_exp  = ref_mem[ea[14:0]];
      end
      if (g_sd) begin
        ref_mem[ea[14:0]] = sdd;
        if (sd_cnt % ROW_LEN == ROW_LEN - 1) begin
          done_at  = cyc + 1;
          done_idx = ((sd_cnt / ROW_LEN) % 2) != 0;
        end
        sd_cnt++;
      end
      if (g_wb) begin
        ref_mem[ea[14:0]] = wbd;
        wb_cnt++;
      end
      if (fs) begin
        sd_cnt = 0; wb_cnt = 0;
      end
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  initial begin
    // Bring registers out of their power-up state before the checked reset cycle.
    @(posedge i_clk);
    #1;
    // Reset with every requester active: nothing may be granted.
    step(1'b1, 1'b0, 13'd0, 1'b1, 32'h1, 1'b1, 32'h2, 1'b0, 1'b1);
    // Three sd words land at 0,1,2.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 13'd0, 1'b1, 32'hA0 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b0);
    // Rewind, then a full row plus one word: row_done for row 0, next word at 0x2000.
    step(1'b0, 1'b0, 13'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i <= ROW_LEN; i++)
      step(1'b0, 1'b0, 13'd0, 1'b1, 32'h1000_0000 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 13'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    // Fill row 1 up to column 5, the last word being 0xDEADBEEF, then read it back.
    for (int i = 1; i <= 5; i++)
      step(1'b0, 1'b0, 13'd0, 1'b1, (i == 5) ? 32'hDEADBEEF : 32'(i), 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 13'd5, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 13'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 13'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    // All three requesters at once: read, wait, sd, wb.
    step(1'b1, 1'b0, 13'd1, 1'b1, 32'h5D5D, 1'b1, 32'hB0B0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 13'd0, 1'b1, 32'h5D5D, 1'b1, 32'hB0B0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 13'd0, 1'b1, 32'h5D5D, 1'b1, 32'hB0B0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 13'd0, 1'b0, 32'h0, 1'b1, 32'hB0B0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 13'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    // Output pointer wrap: rewind, then five wb words.
    step(1'b0, 1'b0, 13'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 13'd0, 1'b0, 32'h0, 1'b1, 32'hC000 + 32'(i), 1'b0, 1'b0);
    // Reset while a read is outstanding: the read is dropped.
    step(1'b1, 1'b0, 13'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 13'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 13'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 13'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(2) == 0, 1'($urandom_range(1)), 13'($urandom_range(31)),
           1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), $urandom,
           $urandom_range(63) == 0, $urandom_range(255) == 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
